// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate into the immediate fields of a RISC-V
// instruction word (I/S/B/J/U), selected by immsel. It is the inverse of the
// immediate generator, so decoding out_instr with the same immsel returns imm.
//
// Two register stages with a valid/ready handshake on both sides:
//   S1 captures the request, S2 packs the word and is the output register.
// Illegal immsel values (2, 6, 7) pass base through unchanged and flag out_err.
// A sticky error flag and a saturating error counter track error beats that
// complete an output handshake.
//
// Optional build macro IMM_RANGE_CHECK_EN: when defined, out_err is also
// raised for immediates that do not fit the selected format. The word is
// still packed from the truncated bits.
module imm_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           immsel,
    input  logic [31:0]          imm,
    input  logic [31:0]          base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Scatter the immediate into the format's bit positions over base.
    function automatic logic [31:0] pack_imm(input logic [2:0]  sel,
                                             input logic [31:0] val,
                                             input logic [31:0] word);
        logic [31:0] w;
        w = word;
        case (sel)
            3'd0: w[31:20] = val[11:0];
            3'd1: begin
                w[31:25] = val[11:5];
                w[11:7]  = val[4:0];
            end
            3'd3: begin
                w[31]    = val[12];
                w[7]     = val[11];
                w[30:25] = val[10:5];
                w[11:8]  = val[4:1];
            end
            3'd4: begin
                w[31]    = val[20];
                w[30:21] = val[10:1];
                w[20]    = val[11];
                w[19:12] = val[19:12];
            end
            3'd5: w[31:12] = val[31:12];
            default: w = word;
        endcase
        return w;
    endfunction

    // True for encodings that do not name an immediate format.
    function automatic logic sel_illegal(input logic [2:0] sel);
        logic bad;
        case (sel)
            3'd0, 3'd1, 3'd3, 3'd4, 3'd5: bad = 1'b0;
            default:                      bad = 1'b1;
        endcase
        return bad;
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    // True when the immediate cannot be represented exactly in the format.
    function automatic logic range_bad(input logic [2:0] sel, input logic [31:0] val);
        logic bad;
        case (sel)
            3'd0, 3'd1: bad = !((val[31:11] == 21'd0) || (val[31:11] == {21{1'b1}}));
            3'd3:       bad = !((val[31:12] == 20'd0) || (val[31:12] == {20{1'b1}})) || val[0];
            3'd4:       bad = !((val[31:20] == 12'd0) || (val[31:20] == {12{1'b1}})) || val[0];
            3'd5:       bad = (val[11:0] != 12'd0);
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction
`endif

    logic        s1_valid_r;
    logic [2:0]  s1_immsel_r;
    logic [31:0] s1_imm_r;
    logic [31:0] s1_base_r;

    logic        s2_load_s;
    logic        accept_s;
    logic        err_s;
    logic        err_hs_s;

    // Handshake control: S2 advance, input acceptance and the error of the S1 beat.
    always_comb begin
        s2_load_s = 1'b0;
        in_ready  = 1'b0;
        accept_s  = 1'b0;
        err_s     = 1'b0;
        err_hs_s  = 1'b0;
        s2_load_s = !out_valid || out_ready;
        if (rst) begin
            in_ready = 1'b0;
        end else begin
            in_ready = !s1_valid_r || s2_load_s;
        end
        accept_s = in_valid && in_ready;
`ifdef IMM_RANGE_CHECK_EN
        err_s = sel_illegal(s1_immsel_r) || range_bad(s1_immsel_r, s1_imm_r);
`else
        err_s = sel_illegal(s1_immsel_r);
`endif
        err_hs_s = out_valid && out_ready && out_err;
    end

    // Stage 1: capture the request on acceptance, drain when S2 takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_immsel_r <= 3'd0;
            s1_imm_r    <= 32'd0;
            s1_base_r   <= 32'd0;
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            s1_immsel_r <= immsel;
            s1_imm_r    <= imm;
            s1_base_r   <= base;
        end else if (s2_load_s) begin
            s1_valid_r  <= 1'b0;
        end
    end

    // Stage 2: pack the word into the output register when it may advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
        end else if (s2_load_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_instr <= pack_imm(s1_immsel_r, s1_imm_r, s1_base_r);
                out_err   <= err_s;
            end
        end
    end

    // Error bookkeeping on completed error beats; the counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (err_hs_s) begin
            err_sticky <= 1'b1;
            if (err_count != {ERR_CNT_W{1'b1}}) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: formats, B/J scatter, illegal select,
// optional range check, backpressure, counter saturation (second instance with
// a 2-bit counter) and reset mid-stream.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  immsel;
    logic [31:0] imm;
    logic [31:0] base;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic        out_err;
    logic        err_sticky;
    logic [7:0]  err_count;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_instr2;
    logic        out_err2;
    logic        err_sticky2;
    logic [1:0]  err_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .immsel(immsel), .imm(imm), .base(base),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .err_sticky(err_sticky), .err_count(err_count)
    );

    imm_encoder #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .immsel(immsel), .imm(imm), .base(base),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
        .out_err(out_err2), .err_sticky(err_sticky2), .err_count(err_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] i, input logic [31:0] b);
        in_valid = v;
        immsel   = s;
        imm      = i;
        base     = b;
    endtask

    // One beat with out_ready high: accept at the next edge, output one edge later.
    task automatic send_check(input string tag, input logic [2:0] s, input logic [31:0] i,
                              input logic [31:0] b, input logic [31:0] exp, input logic exp_err);
        drive(1'b1, s, i, b);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, exp);
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    endtask

    initial begin
        logic exp_range_err;
`ifdef IMM_RANGE_CHECK_EN
        exp_range_err = 1'b1;
`else
        exp_range_err = 1'b0;
`endif
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_sticky", {31'd0, err_sticky}, 32'd0);
        check("rst_count", {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Basic formats and B/J scatter
        send_check("fmt_I", 3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        send_check("fmt_S", 3'd1, 32'h0000_0025, 32'h0000_2023, 32'h0200_22A3, 1'b0);
        send_check("fmt_U", 3'd5, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
        send_check("fmt_B", 3'd3, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        send_check("fmt_J", 3'd4, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
        check("count_before_err", {24'd0, err_count}, 32'd0);

        // Illegal select: base passes through, counted after the handshake
        send_check("illegal6", 3'd6, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        step();
        check("illegal_count", {24'd0, err_count}, 32'd1);
        check("illegal_sticky", {31'd0, err_sticky}, 32'd1);

        // Out-of-range I immediate: flagged only when the range check is built in
        send_check("range_I", 3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, exp_range_err);
        step();

        // Backpressure: 4 beats, out_ready low for 3 cycles mid-stream
        drive(1'b1, 3'd0, 32'd1, 32'h0000_0013);
        step();
        drive(1'b1, 3'd0, 32'd2, 32'h0000_0013);
        step();
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'd3, 32'h0000_0013);
        #1;
        check("bp_first", out_instr, 32'h0010_0013);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_hold_instr", out_instr, 32'h0010_0013);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_beat2", out_instr, 32'h0020_0013);
        drive(1'b1, 3'd0, 32'd4, 32'h0000_0013);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        check("bp_beat3", out_instr, 32'h0030_0013);
        step();
        check("bp_beat4", out_instr, 32'h0040_0013);
        check("bp_beat4_valid", {31'd0, out_valid}, 32'd1);
        step();
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);

        // Saturation: fresh start, 5 illegal beats back to back
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b1, 3'd7, 32'd0, 32'h0000_1111);
        for (int n = 0; n < 5; n++) step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        for (int n = 0; n < 3; n++) step();
        check("sat_count2", {30'd0, err_count2}, 32'd3);
        check("sat_sticky2", {31'd0, err_sticky2}, 32'd1);
        check("sat_count8", {24'd0, err_count}, 32'd5);

        // Reset with two beats in flight
        drive(1'b1, 3'd0, 32'd5, 32'h0000_0013);
        step();
        drive(1'b1, 3'd0, 32'd6, 32'h0000_0013);
        step();
        check("mid_out_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_count", {24'd0, err_count}, 32'd0);
        check("mid_rst_sticky", {31'd0, err_sticky}, 32'd0);
        check("mid_rst_instr", out_instr, 32'd0);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
